// File: rtl/rv32_fetch_stage.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// rv32_fetch_stage
//
// Instruction-fetch stage for the RV32I core. Owns the PC, issues in-order
// word reads to instruction memory, buffers returned instructions together
// with their PCs and presents them to decode on a valid/ready stream.
// Redirects from execute squash all wrong-path work.
//
// Parameters
//   RESET_ADDR       PC after reset (bits [1:0] must be 0)
//   MAX_OUTSTANDING  credit limit: in-flight requests + buffered instructions
//
// Ports
//   clk             rising-edge clock
//   rst             synchronous, active-low reset
//   enable          1 = may issue new requests; 0 = hold issue, keep draining
//   redirect_valid  redirect PC this cycle
//   redirect_addr   new PC, bits [1:0] ignored
//   mem_req_valid   read request valid
//   mem_req_ready   memory accepts request
//   mem_req_addr    word address of request (current PC)
//   mem_resp_valid  read data valid, responses return in request order
//   mem_resp_data   instruction word
//   inst_valid      instruction available to decode
//   inst_ready      decode accepts instruction
//   inst_data       raw instruction
//   inst_pc         PC of inst_data
// ---------------------------------------------------------------------------
module rv32_fetch_stage #(
  parameter logic [31:0] RESET_ADDR      = 32'h0000_0000,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_addr,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_req_addr,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_resp_data,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc
);

  localparam int unsigned DEPTH = MAX_OUTSTANDING;
  localparam int unsigned CW    = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned SUMW  = CW + 1;
  localparam int unsigned PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [SUMW-1:0] MAX_CREDIT = SUMW'(MAX_OUTSTANDING);
  localparam logic [PW-1:0]   LAST_IDX   = PW'(DEPTH - 1);

  // Architectural state
  logic [31:0]   pc_q, pc_d;
  logic [CW-1:0] outst_q, outst_d;   // requests accepted, response not yet seen
  logic [CW-1:0] drop_q, drop_d;     // oldest in-flight responses that are wrong-path
  logic [CW-1:0] occ_q, occ_d;       // buffered instructions

  // Pending-address FIFO: PCs of in-flight requests that are still on the right path
  logic [31:0]   addr_mem_q [DEPTH];
  logic [PW-1:0] addr_wr_q, addr_wr_d;
  logic [PW-1:0] addr_rd_q, addr_rd_d;

  // Instruction FIFO: returned words paired with their PCs
  logic [31:0]   inst_data_mem_q [DEPTH];
  logic [31:0]   inst_pc_mem_q   [DEPTH];
  logic [PW-1:0] inst_wr_q, inst_wr_d;
  logic [PW-1:0] inst_rd_q, inst_rd_d;

  logic [SUMW-1:0] credit_used;
  logic            req_fire;
  logic            resp_fire;
  logic            resp_keep;
  logic            resp_drop;
  logic            inst_pop;
  logic            addr_push;
  logic            inst_push;

  // Low address bits of a redirect are architecturally ignored.
  logic unused_redirect_lsbs;
  assign unused_redirect_lsbs = ^redirect_addr[1:0];

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_IDX) ? '0 : p + PW'(1);
  endfunction

  // Issue depends only on registered counts and enable, so neither redirect
  // nor response inputs reach the request interface combinationally.
  assign credit_used   = {1'b0, outst_q} + {1'b0, occ_q};
  assign mem_req_valid = enable && (credit_used < MAX_CREDIT);
  assign mem_req_addr  = pc_q;

  assign inst_valid = (occ_q != '0);
  assign inst_data  = inst_data_mem_q[inst_rd_q];
  assign inst_pc    = inst_pc_mem_q[inst_rd_q];

  assign req_fire  = mem_req_valid && mem_req_ready;
  // A response with nothing outstanding can only be a leftover from before
  // reset; ignoring it keeps the counters from wrapping.
  assign resp_fire = mem_resp_valid && (outst_q != '0);
  assign resp_drop = resp_fire && (drop_q != '0);
  assign resp_keep = resp_fire && (drop_q == '0);
  assign inst_pop  = inst_valid && inst_ready;

  // A redirect flushes the FIFOs, so nothing from that cycle is written.
  assign addr_push = req_fire && !redirect_valid;
  assign inst_push = resp_keep && !redirect_valid;

  always_comb begin
    outst_d   = outst_q + CW'(req_fire) - CW'(resp_fire);
    pc_d      = pc_q;
    drop_d    = drop_q;
    occ_d     = occ_q;
    addr_wr_d = addr_wr_q;
    addr_rd_d = addr_rd_q;
    inst_wr_d = inst_wr_q;
    inst_rd_d = inst_rd_q;

    if (redirect_valid) begin
      // Every request still in flight after this edge (including one accepted
      // now) belongs to the old path; a response arriving now is discarded.
      pc_d      = {redirect_addr[31:2], 2'b00};
      drop_d    = outst_d;
      occ_d     = '0;
      addr_wr_d = '0;
      addr_rd_d = '0;
      inst_wr_d = '0;
      inst_rd_d = '0;
    end else begin
      if (req_fire) begin
        pc_d      = pc_q + 32'd4;
        addr_wr_d = ptr_inc(addr_wr_q);
      end
      if (resp_drop) begin
        drop_d = drop_q - CW'(1);
      end
      if (resp_keep) begin
        addr_rd_d = ptr_inc(addr_rd_q);
        inst_wr_d = ptr_inc(inst_wr_q);
      end
      if (inst_pop) begin
        inst_rd_d = ptr_inc(inst_rd_q);
      end
      occ_d = occ_q + CW'(resp_keep) - CW'(inst_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pc_q      <= RESET_ADDR;
      outst_q   <= '0;
      drop_q    <= '0;
      occ_q     <= '0;
      addr_wr_q <= '0;
      addr_rd_q <= '0;
      inst_wr_q <= '0;
      inst_rd_q <= '0;
    end else begin
      pc_q      <= pc_d;
      outst_q   <= outst_d;
      drop_q    <= drop_d;
      occ_q     <= occ_d;
      addr_wr_q <= addr_wr_d;
      addr_rd_q <= addr_rd_d;
      inst_wr_q <= inst_wr_d;
      inst_rd_q <= inst_rd_d;
    end
  end

  // FIFO storage needs no reset: pointers and counts define what is valid.
  always_ff @(posedge clk) begin
    if (addr_push) begin
      addr_mem_q[addr_wr_q] <= pc_q;
    end
    if (inst_push) begin
      inst_data_mem_q[inst_wr_q] <= mem_resp_data;
      inst_pc_mem_q[inst_wr_q]   <= addr_mem_q[addr_rd_q];
    end
  end

endmodule

// File: tb/tb_rv32_fetch_stage.sv
`timescale 1ns/1ps
module tb_rv32_fetch_stage;

  localparam int          MAXO = 2;
  localparam logic [31:0] RA2  = 32'hFFFF_FFF8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Main DUT: default parameters
  logic        rst = 1'b0, enable = 1'b0, redirect_valid = 1'b0;
  logic [31:0] redirect_addr = '0;
  logic        mem_req_valid, mem_req_ready = 1'b0;
  logic [31:0] mem_req_addr;
  logic        mem_resp_valid = 1'b0;
  logic [31:0] mem_resp_data = '0;
  logic        inst_valid, inst_ready = 1'b0;
  logic [31:0] inst_data, inst_pc;

  rv32_fetch_stage #(.RESET_ADDR(32'h0), .MAX_OUTSTANDING(MAXO)) dut (
    .clk(clk), .rst(rst), .enable(enable),
    .redirect_valid(redirect_valid), .redirect_addr(redirect_addr),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_data(inst_data), .inst_pc(inst_pc)
  );

  // Second DUT: wrapping reset address, deeper credit for a full-rate stream
  logic        rst2 = 1'b0, en2 = 1'b0, redir2 = 1'b0;
  logic [31:0] raddr2 = '0;
  logic        rv2, rr2 = 1'b0;
  logic [31:0] ra2;
  logic        rsv2 = 1'b0;
  logic [31:0] rsd2 = '0;
  logic        iv2, ir2 = 1'b0;
  logic [31:0] id2, ipc2;

  rv32_fetch_stage #(.RESET_ADDR(RA2), .MAX_OUTSTANDING(3)) dut2 (
    .clk(clk), .rst(rst2), .enable(en2),
    .redirect_valid(redir2), .redirect_addr(raddr2),
    .mem_req_valid(rv2), .mem_req_ready(rr2), .mem_req_addr(ra2),
    .mem_resp_valid(rsv2), .mem_resp_data(rsd2),
    .inst_valid(iv2), .inst_ready(ir2), .inst_data(id2), .inst_pc(ipc2)
  );

  int checks = 0;
  int errors = 0;

  // Memory contents: a PC-dependent pattern so mispaired data/PC is visible
  function automatic logic [31:0] dfun(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic chk1(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- table-driven vectors ----------------
  typedef struct {
    bit          en;
    bit          redir;
    logic [31:0] raddr;
    bit          rr;
    bit          rsv;
    logic [31:0] rsa;    // address whose data is returned this cycle
    bit          ir;
    bit          e_rv;
    logic [31:0] e_ra;
    bit          e_iv;
    logic [31:0] e_ipc;
  } vec_t;

  function automatic vec_t mk(bit en, bit redir, logic [31:0] raddr, bit rr, bit rsv,
                              logic [31:0] rsa, bit ir, bit e_rv, logic [31:0] e_ra,
                              bit e_iv, logic [31:0] e_ipc);
    vec_t v;
    v.en = en; v.redir = redir; v.raddr = raddr; v.rr = rr; v.rsv = rsv; v.rsa = rsa;
    v.ir = ir; v.e_rv = e_rv; v.e_ra = e_ra; v.e_iv = e_iv; v.e_ipc = e_ipc;
    return v;
  endfunction

  vec_t vecs [20];

  // ---------------- behavioural reference model ----------------
  typedef struct { logic [31:0] pc; bit stale; } infl_t;
  typedef struct { logic [31:0] pc; logic [31:0] data; } inst_t;
  typedef struct { logic [31:0] addr; int due; } memreq_t;

  infl_t       infl_q [$];  // requests the memory still owes, oldest first
  inst_t       buf_q  [$];  // instructions waiting for decode
  memreq_t     mem_q  [$];  // bench memory: accepted requests and their ready time
  logic [31:0] pc_m;
  int          cyc;
  int          lat_extra;

  task automatic model_reset();
    infl_q.delete();
    buf_q.delete();
    mem_q.delete();
    pc_m = 32'h0;
    cyc  = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0; enable = 1'b0; redirect_valid = 1'b0; mem_req_ready = 1'b0;
    mem_resp_valid = 1'b0; inst_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    #1;
    chk1("reset req_valid", mem_req_valid, 1'b0);
    chk1("reset inst_valid", inst_valid, 1'b0);
    chk32("reset req_addr", mem_req_addr, 32'h0);
    enable = 1'b1;
    #1;
    chk1("reset credit cleared", mem_req_valid, 1'b1);
    enable = 1'b0;
    rst = 1'b1;
    model_reset();
  endtask

  // One clock cycle: drive inputs, compare against the model, advance the model.
  task automatic step(input bit en_i, input bit redir_i, input logic [31:0] raddr_i,
                      input bit rr_i, input bit ir_i, input bit resp_en);
    bit          e_rv, e_iv, fire, pop, rsp;
    logic [31:0] rdata;
    infl_t       h;
    memreq_t     m;
    @(negedge clk);
    rsp   = resp_en && (mem_q.size() > 0) && (mem_q[0].due <= cyc);
    rdata = rsp ? dfun(mem_q[0].addr) : $urandom();
    enable = en_i; redirect_valid = redir_i; redirect_addr = raddr_i;
    mem_req_ready = rr_i; inst_ready = ir_i;
    mem_resp_valid = rsp; mem_resp_data = rdata;
    #1;
    e_rv = en_i && ((infl_q.size() + buf_q.size()) < MAXO);
    e_iv = (buf_q.size() > 0);
    chk1("req_valid", mem_req_valid, e_rv);
    chk32("req_addr", mem_req_addr, pc_m);
    chk1("inst_valid", inst_valid, e_iv);
    if (e_iv) begin
      chk32("inst_pc", inst_pc, buf_q[0].pc);
      chk32("inst_data", inst_data, buf_q[0].data);
    end
    fire = e_rv && rr_i;
    pop  = e_iv && ir_i;
    if (pop) begin
      $display("inst  pc=%h data=%h%s", buf_q[0].pc, buf_q[0].data, redir_i ? " (wrong path)" : "");
      void'(buf_q.pop_front());
    end
    if (rsp) begin
      m = mem_q.pop_front();
      h = infl_q.pop_front();
      if (!h.stale) buf_q.push_back('{pc: h.pc, data: rdata});
    end
    if (fire) begin
      infl_q.push_back('{pc: pc_m, stale: 1'b0});
      mem_q.push_back('{addr: pc_m, due: cyc + 1 + int'($urandom_range(0, lat_extra))});
      pc_m = pc_m + 32'd4;
    end
    if (redir_i) begin
      foreach (infl_q[i]) infl_q[i].stale = 1'b1;
      buf_q.delete();
      pc_m = {raddr_i[31:2], 2'b00};
    end
    cyc++;
  endtask

  initial begin
    logic [31:0] rnd_addr;
    logic [31:0] ea, ep;

    // Basic stream, credit stall, drain, then a redirect with two in flight
    vecs[0]  = mk(1,0,0,1,0,0,1,          1,0,0,0);
    vecs[1]  = mk(1,0,0,1,1,0,1,          1,4,0,0);
    vecs[2]  = mk(1,0,0,1,1,4,1,          0,8,1,0);
    vecs[3]  = mk(1,0,0,1,0,0,1,          1,8,1,4);
    vecs[4]  = mk(1,0,0,1,1,8,1,          1,12,0,0);
    vecs[5]  = mk(1,0,0,1,1,12,1,         0,16,1,8);
    vecs[6]  = mk(1,0,0,1,0,0,1,          1,16,1,12);
    vecs[7]  = mk(1,0,0,1,1,16,0,         1,20,0,0);
    vecs[8]  = mk(1,0,0,1,1,20,0,         0,24,1,16);
    vecs[9]  = mk(1,0,0,1,0,0,0,          0,24,1,16);
    vecs[10] = mk(1,0,0,1,0,0,1,          0,24,1,16);
    vecs[11] = mk(1,0,0,1,0,0,1,          1,24,1,20);
    vecs[12] = mk(1,0,0,1,0,0,1,          1,28,0,0);
    vecs[13] = mk(1,1,32'h103,1,0,0,1,    0,32,0,0);
    vecs[14] = mk(1,0,0,1,1,24,1,         0,32'h100,0,0);
    vecs[15] = mk(1,0,0,1,1,28,1,         1,32'h100,0,0);
    vecs[16] = mk(1,0,0,1,1,32'h100,1,    1,32'h104,0,0);
    vecs[17] = mk(1,0,0,1,0,0,1,          0,32'h108,1,32'h100);
    vecs[18] = mk(1,0,0,1,1,32'h104,1,    1,32'h108,0,0);
    vecs[19] = mk(1,0,0,1,0,0,1,          0,32'h10C,1,32'h104);

    lat_extra = 0;
    do_reset();

    foreach (vecs[i]) begin
      @(negedge clk);
      enable = vecs[i].en; redirect_valid = vecs[i].redir; redirect_addr = vecs[i].raddr;
      mem_req_ready = vecs[i].rr; mem_resp_valid = vecs[i].rsv;
      mem_resp_data = dfun(vecs[i].rsa); inst_ready = vecs[i].ir;
      #1;
      $display("vec %0d req_valid=%b addr=%h inst_valid=%b pc=%h", i, mem_req_valid,
               mem_req_addr, inst_valid, inst_pc);
      chk1($sformatf("v%0d req_valid", i), mem_req_valid, vecs[i].e_rv);
      chk32($sformatf("v%0d req_addr", i), mem_req_addr, vecs[i].e_ra);
      chk1($sformatf("v%0d inst_valid", i), inst_valid, vecs[i].e_iv);
      if (vecs[i].e_iv) begin
        chk32($sformatf("v%0d inst_pc", i), inst_pc, vecs[i].e_ipc);
        chk32($sformatf("v%0d inst_data", i), inst_data, dfun(vecs[i].e_ipc));
      end
    end

    // Reset with a request still in flight
    do_reset();

    // Redirect in the same cycle as a handshake and a response
    step(1, 0, 0, 1, 1, 1);
    step(1, 1, 32'h0000_0207, 1, 1, 1);
    repeat (6) step(1, 0, 0, 1, 1, 1);
    // Back-to-back redirects
    step(1, 1, 32'h0000_0400, 1, 1, 1);
    step(1, 1, 32'h0000_0802, 1, 0, 1);
    repeat (6) step(1, 0, 0, 1, 1, 1);
    // Memory not ready for three cycles, then enable drops with insts buffered
    repeat (3) step(1, 0, 0, 0, 1, 1);
    repeat (3) step(1, 0, 0, 1, 0, 1);
    repeat (5) step(0, 0, 0, 1, 1, 1);
    repeat (4) step(1, 0, 0, 1, 1, 1);

    // Randomised traffic with variable memory latency
    lat_extra = 2;
    for (int n = 0; n < 800; n++) begin
      rnd_addr = $urandom();
      step($urandom_range(0, 7) != 0, $urandom_range(0, 15) == 0, rnd_addr,
           $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, $urandom_range(0, 3) != 0);
    end

    // Reset mid-operation, then resume from the reset address
    do_reset();
    lat_extra = 0;
    repeat (8) step(1, 0, 0, 1, 1, 1);

    // Wrapping reset address on the second instance, full-rate stream
    rst2 = 1'b0;
    repeat (2) @(posedge clk);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      rst2 = 1'b1; en2 = 1'b1; rr2 = 1'b1; ir2 = 1'b1;
      rsv2 = (k >= 1);
      rsd2 = (k >= 1) ? dfun(RA2 + 32'(4 * (k - 1))) : 32'h0;
      #1;
      ea = RA2 + 32'(4 * k);
      $display("wrap k=%0d req_addr=%h inst_valid=%b pc=%h", k, ra2, iv2, ipc2);
      chk1($sformatf("wrap%0d req_valid", k), rv2, 1'b1);
      chk32($sformatf("wrap%0d req_addr", k), ra2, ea);
      if (k >= 2) begin
        ep = RA2 + 32'(4 * (k - 2));
        chk1($sformatf("wrap%0d inst_valid", k), iv2, 1'b1);
        chk32($sformatf("wrap%0d inst_pc", k), ipc2, ep);
        chk32($sformatf("wrap%0d inst_data", k), id2, dfun(ep));
      end else begin
        chk1($sformatf("wrap%0d inst_valid", k), iv2, 1'b0);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
